// File: rtl/switch_press_encoder.sv
// Four-channel front-panel switch encoder: sync, debounce, rise detect,
// then serialise press events as an index strobe with a running count.
module switch_press_encoder #(
  parameter  int DEBOUNCE_CYCLES = 250_000,
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] sw_i,
  output logic [3:0] sw_level_o,
  output logic       press_valid_o,
  output logic [1:0] press_idx_o,
  output logic [7:0] press_count_o,
  output logic       busy_o
);

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       s1;
  logic [3:0]       s2;
  logic [3:0]       level;
  logic [3:0]       level_q;
  logic [3:0]       pending;
  logic [3:0]       pending_nx;
  logic [3:0]       lowest;
  logic [CNT_W-1:0] cnt [4];
  logic [1:0]       last_idx;
  logic [1:0]       sel_idx;
  logic [7:0]       count;
  logic             busy_q;

  // isolate the lowest pending bit so the decoder sees a one-hot
  always_comb begin
    lowest = pending & (~pending + 4'd1);
    sel_idx = last_idx;
    unique case (1'b1)
      lowest[0]: sel_idx = 2'd0;
      lowest[1]: sel_idx = 2'd1;
      lowest[2]: sel_idx = 2'd2;
      lowest[3]: sel_idx = 2'd3;
      default:   sel_idx = last_idx;
    endcase
    pending_nx = (pending & ~lowest) | (level & ~level_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1       <= '0;
      s2       <= '0;
      level    <= '0;
      level_q  <= '0;
      pending  <= '0;
      busy_q   <= 1'b0;
      last_idx <= '0;
      count    <= '0;
      for (int n = 0; n < 4; n++) begin
        cnt[n] <= '0;
      end
    end else begin
      s1      <= sw_i;
      s2      <= s1;
      level_q <= level;
      pending <= pending_nx;
      busy_q  <= |pending_nx;
      for (int n = 0; n < 4; n++) begin
        if (s2[n] != level[n]) begin
          if (cnt[n] == CNT_LAST) begin
            level[n] <= s2[n];
            cnt[n]   <= '0;
          end else begin
            cnt[n] <= cnt[n] + CNT_W'(1);
          end
        end else begin
          cnt[n] <= '0;
        end
      end
      if (|pending) begin
        last_idx <= sel_idx;
        count    <= count + 8'd1;
      end
    end
  end

  assign sw_level_o    = level;
  assign press_valid_o = |pending;
  assign press_idx_o   = sel_idx;
  assign press_count_o = count;
  assign busy_o        = busy_q;

endmodule
